// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime frame format, input synchroniser, 3-sample
// majority vote, break detection and a show-ahead RX FIFO carrying per-entry
// error flags. Sits between the UART pad and the bus-side register block.
module uart_rx_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_i,
  input  logic [15:0]      baud_div,
  input  logic [1:0]       data_bits,
  input  logic [1:0]       parity,
  input  logic             stop2,
  input  logic             rx_en,
  output logic [7:0]       m_data,
  output logic             m_ferr,
  output logic             m_perr,
  output logic             m_brk,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overrun_o,
  input  logic             ovr_clr,
  output logic             break_o
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int M    = OVERSAMPLE / 2;

  // Sample points within one bit: two early samples, then the deciding one.
  localparam logic [OS_W-1:0] OS_S0   = OS_W'(M - 1);
  localparam logic [OS_W-1:0] OS_S1   = OS_W'(M);
  localparam logic [OS_W-1:0] OS_DEC  = OS_W'(M + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BRK
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    logic       brk;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Baud tick generator
  // ---------------------------------------------------------------------------
  logic [15:0] tick_cnt;
  logic        tick;

  assign tick = (tick_cnt == '0);

  // Down-counter reloading from baud_div; a new divisor takes effect at reload.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and the simulation order of always blocks cannot matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= baud_div;
    end else begin
      tick_cnt <= tick_cnt - 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic rx_s1;
  logic rx_sync;

  // Two-flop synchroniser, reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_s1   <= rx_i;
      rx_sync <= rx_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t          state;
  logic [OS_W-1:0] os;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [1:0]      samp;
  logic            par_bit;
  logic            perr_r;
  logic            ferr_r;
  logic            stop_idx;

  logic       vote;
  logic       at_dec;
  logic       at_end;
  logic       par_en;
  logic       exp_par;
  logic       brk_cond;
  logic [2:0] last_bit;
  logic       push;
  entry_t     push_entry;

  assign vote     = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);
  assign at_dec   = (os == OS_DEC);
  assign at_end   = (os == OS_LAST);
  assign par_en   = (parity == 2'd1) || (parity == 2'd2);
  assign exp_par  = (parity == 2'd2) ? ~^shreg : ^shreg;
  assign last_bit = {1'b0, data_bits} + 3'd4;
  // Break: every data bit, the parity bit (if any) and the first stop bit low.
  assign brk_cond = !stop_idx && !vote && (shreg == '0) && (!par_en || !par_bit);

  // Push request, combinational so the FIFO writes on the push tick itself.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value held and no latch is inferred.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (tick && rx_en && (state == S_STOP) && at_dec) begin
      if (brk_cond) begin
        push            = 1'b1;
        push_entry.ferr = 1'b1;
        push_entry.brk  = 1'b1;
      end else if (stop_idx || !stop2) begin
        push            = 1'b1;
        push_entry.data = shreg;
        push_entry.ferr = ferr_r | !vote;
        push_entry.perr = perr_r;
      end
    end
  end

  // Frame sequencer: advances on ticks only, samples and decides each bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      os       <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      samp     <= '0;
      par_bit  <= 1'b0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
      stop_idx <= 1'b0;
      break_o  <= 1'b0;
    end else begin
      break_o <= 1'b0;
      if (tick) begin
        if (!rx_en) begin
          state <= S_IDLE;
        end else begin
          case (state)
            S_IDLE: begin
              if (!rx_sync) begin
                state    <= S_START;
                os       <= '0;
                bit_idx  <= '0;
                shreg    <= '0;
                par_bit  <= 1'b0;
                perr_r   <= 1'b0;
                ferr_r   <= 1'b0;
                stop_idx <= 1'b0;
              end
            end

            S_BRK: begin
              if (rx_sync) state <= S_IDLE;
            end

            default: begin
              os <= at_end ? '0 : os + OS_W'(1);
              if (os == OS_S0) samp[0] <= rx_sync;
              if (os == OS_S1) samp[1] <= rx_sync;

              if (at_dec) begin
                case (state)
                  S_START: if (vote) state <= S_IDLE;
                  S_DATA:  shreg[bit_idx] <= vote;
                  S_PAR: begin
                    par_bit <= vote;
                    perr_r  <= (vote != exp_par);
                  end
                  S_STOP: begin
                    if (brk_cond) begin
                      state   <= S_BRK;
                      break_o <= 1'b1;
                    end else if (stop_idx || !stop2) begin
                      state <= S_IDLE;
                    end else begin
                      ferr_r <= !vote;
                    end
                  end
                  default: ;
                endcase
              end

              if (at_end) begin
                case (state)
                  S_START: begin
                    state   <= S_DATA;
                    bit_idx <= '0;
                  end
                  S_DATA: begin
                    if (bit_idx == last_bit) begin
                      state <= par_en ? S_PAR : S_STOP;
                    end else begin
                      bit_idx <= bit_idx + 3'd1;
                    end
                  end
                  S_PAR:   state <= S_STOP;
                  S_STOP:  stop_idx <= 1'b1;
                  default: ;
                endcase
              end
            end
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  entry_t             mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LVL_W-1:0]   count;
  logic               full;
  logic               do_push;
  logic               do_pop;
  entry_t             head;

  assign full    = (count == LVL_W'(FIFO_DEPTH));
  assign m_valid = (count != '0);
  assign do_pop  = m_ready && m_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);

  // Storage array.
  // NOTE: the array has no reset; its contents are only observed through the
  // head gating below, which forces zeros whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun: a dropped frame sets it, and setting wins over clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_o <= 1'b0;
    end else if (push && full && !do_pop) begin
      overrun_o <= 1'b1;
    end else if (ovr_clr) begin
      overrun_o <= 1'b0;
    end
  end

  assign head       = mem[rd_ptr];
  assign m_data     = m_valid ? head.data : 8'h00;
  assign m_ferr     = m_valid & head.ferr;
  assign m_perr     = m_valid & head.perr;
  assign m_brk      = m_valid & head.brk;
  assign fifo_level = count;

endmodule
